// File: rtl/dsp48a1_mac_ctrl_if.sv
// Operand stream and result port bundle for the DSP48A1 MAC sequencer.
// The master side produces operand pairs and consumes results; the slave
// side is the sequencer.
interface dsp48a1_mac_ctrl_if #(
    parameter int A_DATA_WIDTH = 18,
    parameter int B_DATA_WIDTH = 18,
    parameter int P_DATA_WIDTH = 48,
    parameter int CNT_WIDTH    = 16
) ();
    logic                    S_VALID;
    logic                    S_READY;
    logic [A_DATA_WIDTH-1:0] S_A;
    logic [B_DATA_WIDTH-1:0] S_B;
    logic                    S_LAST;
    logic                    M_VALID;
    logic                    M_READY;
    logic [P_DATA_WIDTH-1:0] M_P;
    logic [CNT_WIDTH-1:0]    M_COUNT;

    modport master (
        output S_VALID, S_A, S_B, S_LAST, M_READY,
        input  S_READY, M_VALID, M_P, M_COUNT
    );

    modport slave (
        input  S_VALID, S_A, S_B, S_LAST, M_READY,
        output S_READY, M_VALID, M_P, M_COUNT
    );
endinterface

// File: rtl/dsp48a1_mac_ctrl.sv
// Upstream sequencer for a DSP48A1 slice configured with A1/B1/M/P/OPMODE
// registers. Operand pairs are forwarded to the slice, OPMODE selects a
// fresh product or product+P, CEP is pulsed once per term as it reaches
// the P stage, and the final P of each vector is captured into a
// single-entry result register with a valid/ready handshake.
module dsp48a1_mac_ctrl #(
    parameter int A_DATA_WIDTH = 18,
    parameter int B_DATA_WIDTH = 18,
    parameter int P_DATA_WIDTH = 48,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    dsp48a1_mac_ctrl_if.slave       bus,
    output logic [A_DATA_WIDTH-1:0] DSP_A,
    output logic [B_DATA_WIDTH-1:0] DSP_B,
    output logic [7:0]              DSP_OPMODE,
    output logic                    DSP_CE,
    output logic                    DSP_CEP,
    output logic                    DSP_RST,
    input  logic [P_DATA_WIDTH-1:0] DSP_P
);

    // X=M, Z=0 starts a new sum; X=M, Z=P accumulates; no pre-adder, CIN=0
    localparam logic [7:0] OPM_FIRST = 8'h01;
    localparam logic [7:0] OPM_ACC   = 8'h09;
    localparam logic [7:0] OPM_IDLE  = 8'h00;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_s_ready;
    logic                    w_m_valid;
    logic                    w_accept;

    logic                    r_first_term;
    logic                    r_ce;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic [A_DATA_WIDTH-1:0] r_dsp_a_p1;
    logic [B_DATA_WIDTH-1:0] r_dsp_b_p1;
    logic                    r_vld_p1;
    logic                    r_first_p1;
    logic                    r_last_p1;
    logic                    r_vld_p2;
    logic                    r_last_p2;
    logic [7:0]              r_opmode_p2;
    logic                    r_vld_p3;
    logic                    r_last_p3;
    logic                    r_cap_p4;
    logic [P_DATA_WIDTH-1:0] r_m_p;
    logic [CNT_WIDTH-1:0]    r_m_count;

    assign w_accept    = bus.S_VALID && w_s_ready;
    assign bus.S_READY = w_s_ready;
    assign bus.M_VALID = w_m_valid;
    assign bus.M_P     = r_m_p;
    assign bus.M_COUNT = r_m_count;
    assign DSP_A       = r_dsp_a_p1;
    assign DSP_B       = r_dsp_b_p1;
    assign DSP_OPMODE  = r_opmode_p2;
    assign DSP_CE      = r_ce;
    assign DSP_CEP     = r_vld_p3;
    assign DSP_RST     = RST;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake outputs: accept only while accumulating,
    // present the result only while holding it
    always_comb begin
        w_state_nxt = r_state;
        w_s_ready   = 1'b0;
        w_m_valid   = 1'b0;
        unique case (r_state)
            ACCUM: begin
                w_s_ready = ~RST;
                if (bus.S_VALID && bus.S_LAST) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (r_cap_p4) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                w_m_valid = 1'b1;
                if (bus.M_READY) begin
                    w_state_nxt = ACCUM;
                end
            end
            default: w_state_nxt = ACCUM;
        endcase
    end

    // Term pipeline control: tracks each accepted term through the A1/B1,
    // M and P stages of the slice, plus the capture slot after P settles
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ce         <= 1'b0;
            r_first_term <= 1'b1;
            r_vld_p1     <= 1'b0;
            r_first_p1   <= 1'b0;
            r_last_p1    <= 1'b0;
            r_vld_p2     <= 1'b0;
            r_last_p2    <= 1'b0;
            r_opmode_p2  <= OPM_IDLE;
            r_vld_p3     <= 1'b0;
            r_last_p3    <= 1'b0;
            r_cap_p4     <= 1'b0;
        end else begin
            r_ce <= 1'b1;
            // p0 -> p1: operands leave for the slice input registers
            r_vld_p1  <= w_accept;
            r_last_p1 <= w_accept && bus.S_LAST;
            if (w_accept) begin
                r_first_p1   <= r_first_term;
                r_first_term <= bus.S_LAST;
            end
            // p1 -> p2: OPMODE aligned with the product entering M
            r_vld_p2    <= r_vld_p1;
            r_last_p2   <= r_last_p1;
            r_opmode_p2 <= r_vld_p1 ? (r_first_p1 ? OPM_FIRST : OPM_ACC) : OPM_IDLE;
            // p2 -> p3: CEP enables the P update of this term only
            r_vld_p3  <= r_vld_p2;
            r_last_p3 <= r_last_p2;
            // p3 -> p4: P now holds the finished sum
            r_cap_p4  <= r_last_p3;
        end
    end

    // Term counter: saturating per accept, restarted when a result is taken
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (r_cap_p4) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= sat_inc(r_cnt);
        end
    end

    // Operand registers feeding the slice; held across bubbles
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_dsp_a_p1 <= '0;
            r_dsp_b_p1 <= '0;
        end else if (w_accept) begin
            r_dsp_a_p1 <= bus.S_A;
            r_dsp_b_p1 <= bus.S_B;
        end
    end

    // Result register: loaded from P once the last term has settled
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_m_p     <= '0;
            r_m_count <= '0;
        end else if (r_cap_p4) begin
            r_m_p     <= DSP_P;
            r_m_count <= r_cnt;
        end
    end

endmodule
